// File: rtl/pwm_led_pkg.sv
// pwm_led_pkg: shared duty helpers for the multi-channel LED PWM dimmer.
// Duty values are CNT_W+1 bits wide (0..FULL, FULL = 2^CNT_W). Because the
// width is a parameter of the top, the helpers work on a wide container
// type and the caller casts the result back to its own duty width.
package pwm_led_pkg;

  // Widest supported period counter; wide_t has headroom for CNT_W+2-bit
  // intermediates (step up before saturation) at that width.
  localparam int MAX_CNT_W = 31;

  typedef logic [MAX_CNT_W+1:0] wide_t;

  // FULL duty for a given counter width: output held constantly high.
  function automatic wide_t full_of(input int cnt_w);
    return wide_t'(1) << cnt_w;
  endfunction

  // Clamp a duty value to 0..FULL.
  function automatic wide_t duty_sat(input wide_t v, input int cnt_w);
    return (v > full_of(cnt_w)) ? full_of(cnt_w) : v;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-FF synchroniser, stability counter and rising-edge pulse
// for one raw push-button.
// Ports:
//   clk, rst - clock, asynchronous active-high reset
//   raw      - asynchronous button level
//   pulse    - one-cycle pulse when the debounced level rises
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic pulse
);

  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [DW-1:0] LIM = DW'(DEBOUNCE_CYC - 1);

  logic [1:0]    sync;
  logic          level;
  logic [DW-1:0] run;

  // run counts consecutive clocks in which the synchronised level differs
  // from the accepted one; any agreement restarts the count. The level is
  // taken on the DEBOUNCE_CYC-th differing clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync  <= '0;
      level <= 1'b0;
      run   <= '0;
      pulse <= 1'b0;
    end else begin
      sync  <= {sync[0], raw};
      pulse <= 1'b0;
      if (sync[1] == level) begin
        run <= '0;
      end else if (run == LIM) begin
        level <= sync[1];
        run   <= '0;
        pulse <= sync[1];
      end else begin
        run <= run + DW'(1);
      end
    end
  end

endmodule

// File: rtl/pwm_led_multi.sv
// pwm_led_multi: CHANNELS-output LED PWM dimmer sharing one period counter.
// Each channel has a shadow duty (written by buttons or direct writes) and
// an active duty that is loaded from the shadow on the last counter value,
// so a period is never altered mid-way.
// Optional build macro PWM_LED_FADE_EN: the active duty moves toward the
// shadow by at most FADE_STEP per period instead of jumping.
// Ports:
//   in_clk, in_rst                      - clock, async active-high reset
//   in_przycisk_up / in_przycisk_down   - raw buttons, step shadow[in_sel]
//   in_sel                              - channel for steps and writes
//   in_wr_en / in_wr_data               - direct shadow write (saturated)
//   out_led                             - registered PWM outputs
//   out_period_start                    - pulse while out_led shows cnt == 0
module pwm_led_multi
  import pwm_led_pkg::*;
#(
  parameter  int CNT_W        = 16,
  parameter  int CHANNELS     = 4,
  parameter  int STEP         = 6554,
  parameter  int DEBOUNCE_CYC = 100000,
  parameter  int FADE_STEP    = 256,
  localparam int SEL_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                in_clk,
  input  logic                in_rst,
  input  logic                in_przycisk_up,
  input  logic                in_przycisk_down,
  input  logic [SEL_W-1:0]    in_sel,
  input  logic                in_wr_en,
  input  logic [CNT_W:0]      in_wr_data,
  output logic [CHANNELS-1:0] out_led,
  output logic                out_period_start
);

  typedef logic [CNT_W:0] duty_t;

  localparam logic [CNT_W-1:0] LAST   = '1;
  localparam logic [SEL_W:0]   CH_LIM = (SEL_W + 1)'(CHANNELS);

  if (CHANNELS < 1) begin : g_chk_ch
    $error("CHANNELS must be at least 1");
  end
  if (CNT_W > MAX_CNT_W) begin : g_chk_w
    $error("CNT_W exceeds MAX_CNT_W");
  end
  if (FADE_STEP < 1) begin : g_chk_fade
    $error("FADE_STEP must be at least 1");
  end

  logic [CNT_W-1:0] cnt;
  logic             up_evt, dn_evt;
  logic             sel_ok;
  logic             boundary;
  duty_t            wr_sat;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn_up (
    .clk(in_clk), .rst(in_rst), .raw(in_przycisk_up), .pulse(up_evt)
  );
  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn_dn (
    .clk(in_clk), .rst(in_rst), .raw(in_przycisk_down), .pulse(dn_evt)
  );

  assign sel_ok   = ({1'b0, in_sel} < CH_LIM);
  assign boundary = (cnt == LAST);
  assign wr_sat   = duty_t'(duty_sat(wide_t'(in_wr_data), CNT_W));

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      cnt              <= '0;
      out_period_start <= 1'b0;
    end else begin
      cnt              <= cnt + CNT_W'(1);
      out_period_start <= (cnt == '0);
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    duty_t shadow, active, up_val, dn_val, nxt_act;
    logic  hit;
    logic  led;

    assign hit    = sel_ok && (in_sel == SEL_W'(g));
    assign up_val = duty_t'(duty_sat(wide_t'(shadow) + wide_t'(STEP), CNT_W));
    assign dn_val = (wide_t'(shadow) < wide_t'(STEP)) ? '0
                  : duty_t'(wide_t'(shadow) - wide_t'(STEP));

`ifdef PWM_LED_FADE_EN
    // Move at most FADE_STEP toward the shadow; land exactly on it when closer.
    always_comb begin
      nxt_act = shadow;
      if (wide_t'(shadow) > wide_t'(active) + wide_t'(FADE_STEP))
        nxt_act = duty_t'(wide_t'(active) + wide_t'(FADE_STEP));
      else if (wide_t'(active) > wide_t'(shadow) + wide_t'(FADE_STEP))
        nxt_act = duty_t'(wide_t'(active) - wide_t'(FADE_STEP));
    end
`else
    assign nxt_act = shadow;
`endif

    // Direct write beats a same-cycle step; simultaneous up and down cancel.
    always_ff @(posedge in_clk or posedge in_rst) begin
      if (in_rst) begin
        shadow <= '0;
      end else if (hit) begin
        if (in_wr_en)                shadow <= wr_sat;
        else if (up_evt && !dn_evt)  shadow <= up_val;
        else if (dn_evt && !up_evt)  shadow <= dn_val;
      end
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
      if (in_rst) begin
        active <= '0;
        led    <= 1'b0;
      end else begin
        if (boundary) active <= nxt_act;
        led <= ({1'b0, cnt} < active);
      end
    end

    assign out_led[g] = led;
  end

endmodule
